// File: rtl/otter_alu_pkg.sv
// otter_alu_pkg: function codes, FSM state codes and op-class helpers shared by
// the sequential OTTER ALU and its divider.
package otter_alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'b0_0000,
    ALU_SLL    = 5'b0_0001,
    ALU_SLT    = 5'b0_0010,
    ALU_SLTU   = 5'b0_0011,
    ALU_XOR    = 5'b0_0100,
    ALU_SRL    = 5'b0_0101,
    ALU_OR     = 5'b0_0110,
    ALU_AND    = 5'b0_0111,
    ALU_SUB    = 5'b0_1000,
    ALU_LUI    = 5'b0_1001,
    ALU_SRA    = 5'b0_1101,
    ALU_MUL    = 5'b1_0000,
    ALU_MULH   = 5'b1_0001,
    ALU_MULHSU = 5'b1_0010,
    ALU_MULHU  = 5'b1_0011,
    ALU_DIV    = 5'b1_0100,
    ALU_DIVU   = 5'b1_0101,
    ALU_REM    = 5'b1_0110,
    ALU_REMU   = 5'b1_0111
  } alu_fun_t;

  typedef logic [1:0] alu_state_t;
  localparam alu_state_t IDLE = 2'd0;
  localparam alu_state_t MUL  = 2'd1;
  localparam alu_state_t DIV  = 2'd2;
  localparam alu_state_t FIX  = 2'd3;

  function automatic logic is_mul(input logic [4:0] fun);
    return fun[4:2] == 3'b100;
  endfunction

  function automatic logic is_div(input logic [4:0] fun);
    return fun[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/otter_alu_divider.sv
// otter_alu_divider: unsigned restoring divider, one quotient bit per cycle.
// Pulse start with the operands; done pulses once quotient/remainder are final.
module otter_alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   trial, diff;

  // The dividend shifts out of quo_q from the top while quotient bits enter at the bottom.
  always_comb begin
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    done_d = 1'b0;
    trial  = {rem_q, quo_q[WIDTH-1]};
    diff   = trial - {1'b0, dvsr_q};
    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      dvsr_d = divisor;
      cnt_d  = CNT_INIT;
    end else if (cnt_q != '0) begin
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CNT_LAST;
      done_d = (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
      done_q <= done_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/otter_alu_seq.sv
// otter_alu_seq: handshaked OTTER ALU with iterative RV32M multiply and divide.
// Define OTTER_ALU_DIV_EN to build the divider; otherwise DIV/REM codes return 0.
module otter_alu_seq
  import otter_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [4:0]       ALU_FUN,
  input  logic [WIDTH-1:0] ALU_SRC_A,
  input  logic [WIDTH-1:0] ALU_SRC_B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             BUSY
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

  alu_state_t         state_q, state_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   alu_out_q, alu_out_d;

  logic               accept, finish;
  logic               a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, base_res, result;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_nx, prod_fix;

`ifdef OTTER_ALU_DIV_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic               rneg_q, rneg_d, div_start, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;

  otter_alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (CLK),
    .rst_n     (RST_N),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`endif

  assign IN_READY  = RST_N && (state_q == IDLE) && (!out_valid_q || OUT_READY);
  assign accept    = IN_VALID && IN_READY;
  assign OUT_VALID = out_valid_q;
  assign ALU_OUT   = alu_out_q;
  assign BUSY      = (state_q != IDLE);
  assign shamt     = ALU_SRC_B[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (ALU_FUN)
      ALU_ADD:  base_res = ALU_SRC_A + ALU_SRC_B;
      ALU_SUB:  base_res = ALU_SRC_A - ALU_SRC_B;
      ALU_OR:   base_res = ALU_SRC_A | ALU_SRC_B;
      ALU_AND:  base_res = ALU_SRC_A & ALU_SRC_B;
      ALU_XOR:  base_res = ALU_SRC_A ^ ALU_SRC_B;
      ALU_SLL:  base_res = ALU_SRC_A << shamt;
      ALU_SRL:  base_res = ALU_SRC_A >> shamt;
      ALU_SRA:  base_res = $unsigned($signed(ALU_SRC_A) >>> shamt);
      ALU_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(ALU_SRC_A) < $signed(ALU_SRC_B))};
      ALU_SLTU: base_res = {{(WIDTH-1){1'b0}}, (ALU_SRC_A < ALU_SRC_B)};
      ALU_LUI:  base_res = ALU_SRC_A;
      default:  base_res = '0;
    endcase
  end

  // Iterative units work on magnitudes; the sign is restored when the result is written.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    if (is_mul(ALU_FUN)) begin
      a_sgn = (ALU_FUN[1:0] != 2'b11);
      b_sgn = !ALU_FUN[1];
    end else if (is_div(ALU_FUN)) begin
      a_sgn = !ALU_FUN[0];
      b_sgn = !ALU_FUN[0];
    end
    a_neg = a_sgn && ALU_SRC_A[WIDTH-1];
    b_neg = b_sgn && ALU_SRC_B[WIDTH-1];
    a_mag = a_neg ? -ALU_SRC_A : ALU_SRC_A;
    b_mag = b_neg ? -ALU_SRC_B : ALU_SRC_B;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    neg_d       = neg_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    out_valid_d = out_valid_q && !OUT_READY;
    alu_out_d   = alu_out_q;
    finish      = 1'b0;
    result      = '0;
    // prod_q holds {partial sum, remaining multiplier bits}; one shift-add per cycle.
    sum         = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_nx     = {sum, prod_q[WIDTH-1:1]};
    prod_fix    = neg_q ? -prod_nx : prod_nx;
`ifdef OTTER_ALU_DIV_EN
    rneg_d      = rneg_q;
    div_start   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = ALU_FUN[1:0];
          if (is_mul(ALU_FUN)) begin
            state_d = MUL;
            cnt_d   = CNT_INIT;
            prod_d  = {{WIDTH{1'b0}}, b_mag};
            mcand_d = a_mag;
            neg_d   = a_neg ^ b_neg;
          end
`ifdef OTTER_ALU_DIV_EN
          else if (is_div(ALU_FUN)) begin
            if (ALU_SRC_B == '0) begin
              finish = 1'b1;
              result = ALU_FUN[1] ? ALU_SRC_A : '1;
            end else if (!ALU_FUN[0] && ALU_SRC_A == MIN_NEG && ALU_SRC_B == '1) begin
              finish = 1'b1;
              result = ALU_FUN[1] ? '0 : ALU_SRC_A;
            end else begin
              state_d   = DIV;
              cnt_d     = CNT_INIT;
              neg_d     = a_neg ^ b_neg;
              rneg_d    = a_neg;
              div_start = 1'b1;
            end
          end
`endif
          else begin
            finish = 1'b1;
            result = base_res;
          end
        end
      end
      MUL: begin
        prod_d = prod_nx;
        cnt_d  = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          finish  = 1'b1;
          result  = (op_q == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        end
      end
`ifdef OTTER_ALU_DIV_EN
      DIV: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        if (div_done) begin
          state_d = IDLE;
          finish  = 1'b1;
          result  = op_q[1] ? (rneg_q ? -div_rem : div_rem)
                            : (neg_q ? -div_quo : div_quo);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (finish) begin
      out_valid_d = 1'b1;
      alu_out_d   = result;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      prod_q      <= '0;
      mcand_q     <= '0;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
`ifdef OTTER_ALU_DIV_EN
      rneg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
`ifdef OTTER_ALU_DIV_EN
      rneg_q      <= rneg_d;
`endif
    end
  end

endmodule
